// File: rtl/fbc_sample_packer.sv
// Packs 32-bit FBC samples into 256-bit cache words, flushes the partial word at scan end
// and pads the frame with PAD_VALUE words up to a whole number of BURST_WORDS bursts.
module fbc_sample_packer #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BURST_WORDS = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         fbc_scan_en_i,
  input  logic         fbc_data_vld_i,
  input  logic [31:0]  fbc_data_i,
  input  logic         fbc_cache_full_i,
  output logic         fbc_scan_en_o,
  output logic         fbc_cache_vld_o,
  output logic [255:0] fbc_cache_data_o,
  output logic [17:0]  frame_word_cnt_o,
  output logic         overflow_o,
  output logic [2:0]   fsm_state_o
);

  localparam int          LANES      = 256 / DATA_WIDTH;
  localparam int          LW         = $clog2(LANES);
  localparam logic [17:0] BURST_MASK = 18'(BURST_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PACK  = 3'd1,
    S_FLUSH = 3'd2,
    S_ALIGN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                             state;
  logic                               scan_d;
  logic [LW-1:0]                      lane_cnt;
  logic [LANES-1:0][DATA_WIDTH-1:0]   lanes;
  logic [LANES-1:0][DATA_WIDTH-1:0]   fill_word;
  logic [LANES-1:0][DATA_WIDTH-1:0]   flush_word;
  logic                               scan_rise;
  logic                               scan_fall;
  logic                               lane_last;
  logic                               cnt_aligned;
  logic                               cnt_sat;
  logic                               busy_sample;
  logic [17:0]                        cnt_inc;

  assign fsm_state_o = state;
  assign scan_rise   = fbc_scan_en_i & ~scan_d;
  assign scan_fall   = ~fbc_scan_en_i & scan_d;
  assign lane_last   = (lane_cnt == LW'(LANES - 1));
  assign cnt_aligned = ((frame_word_cnt_o & BURST_MASK) == 18'd0);
  assign cnt_sat     = &frame_word_cnt_o;
  assign cnt_inc     = cnt_sat ? frame_word_cnt_o : frame_word_cnt_o + 18'd1;
  // A sample offered outside PACK is only an error while the scan is still asserted.
  assign busy_sample = fbc_data_vld_i & fbc_scan_en_i;

  always_comb begin
    fill_word           = lanes;
    fill_word[lane_cnt] = fbc_data_i[DATA_WIDTH-1:0];
    flush_word          = lanes;
    for (int i = 0; i < LANES; i++) begin
      if (i >= int'(lane_cnt)) flush_word[i] = PAD_VALUE;
    end
  end

  // Word completion decisions (including the full check) are made in the cycle the word
  // becomes due; the strobe and count update appear on the registered outputs one clk later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= S_IDLE;
      scan_d           <= 1'b0;
      lane_cnt         <= '0;
      lanes            <= '0;
      fbc_scan_en_o    <= 1'b0;
      fbc_cache_vld_o  <= 1'b0;
      fbc_cache_data_o <= '0;
      frame_word_cnt_o <= '0;
      overflow_o       <= 1'b0;
    end else begin
      scan_d          <= fbc_scan_en_i;
      fbc_cache_vld_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (scan_rise) begin
            state            <= S_PACK;
            fbc_scan_en_o    <= 1'b1;
            frame_word_cnt_o <= '0;
            overflow_o       <= 1'b0;
            lane_cnt         <= '0;
            lanes            <= '0;
          end else if (busy_sample) begin
            overflow_o <= 1'b1;
          end
        end
        S_PACK: begin
          if (fbc_data_vld_i) begin
            if (lane_last) begin
              lane_cnt <= '0;
              lanes    <= '0;
              if (fbc_cache_full_i) begin
                overflow_o <= 1'b1;
              end else begin
                fbc_cache_data_o <= fill_word;
                fbc_cache_vld_o  <= 1'b1;
                frame_word_cnt_o <= cnt_inc;
              end
            end else begin
              lanes[lane_cnt] <= fbc_data_i[DATA_WIDTH-1:0];
              lane_cnt        <= lane_cnt + LW'(1);
            end
          end
          if (scan_fall) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (busy_sample) overflow_o <= 1'b1;
          if (lane_cnt != '0) begin
            if (fbc_cache_full_i) begin
              overflow_o <= 1'b1;
            end else begin
              fbc_cache_data_o <= flush_word;
              fbc_cache_vld_o  <= 1'b1;
              frame_word_cnt_o <= cnt_inc;
            end
          end
          lane_cnt <= '0;
          lanes    <= '0;
          state    <= S_ALIGN;
        end
        S_ALIGN: begin
          if (busy_sample) overflow_o <= 1'b1;
          // A saturated count can never become aligned, so it also ends the padding.
          if (cnt_aligned || cnt_sat) begin
            state         <= S_DONE;
            fbc_scan_en_o <= 1'b0;
          end else if (!fbc_cache_full_i) begin
            fbc_cache_data_o <= {LANES{PAD_VALUE}};
            fbc_cache_vld_o  <= 1'b1;
            frame_word_cnt_o <= cnt_inc;
          end
        end
        S_DONE: begin
          if (busy_sample) overflow_o <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fbc_sample_packer.sv
// Randomized frames driven into two packers (burst padding 1 and 8); a queue-based
// reference of expected words is popped by per-instance monitors.
module tb_fbc_sample_packer;

  localparam logic [31:0] PAD = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst;
  logic         scan;
  logic         dvld;
  logic [31:0]  data;
  logic         full;

  logic         scan_o1, vld1, ovf1;
  logic [255:0] data1;
  logic [17:0]  cnt1;
  logic [2:0]   st1;
  logic         scan_o8, vld8, ovf8;
  logic [255:0] data8;
  logic [17:0]  cnt8;
  logic [2:0]   st8;

  int tests = 0;
  int fails = 0;

  logic [255:0] exp_q1[$];
  logic [255:0] exp_q8[$];
  logic [31:0]  part[$];
  int           nw;
  bit           ovf_exp;

  always #5 clk = ~clk;

  fbc_sample_packer #(.DATA_WIDTH(32), .BURST_WORDS(1), .PAD_VALUE(PAD)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .fbc_scan_en_i(scan), .fbc_data_vld_i(dvld),
    .fbc_data_i(data), .fbc_cache_full_i(full), .fbc_scan_en_o(scan_o1),
    .fbc_cache_vld_o(vld1), .fbc_cache_data_o(data1), .frame_word_cnt_o(cnt1),
    .overflow_o(ovf1), .fsm_state_o(st1)
  );

  fbc_sample_packer #(.DATA_WIDTH(32), .BURST_WORDS(8), .PAD_VALUE(PAD)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .fbc_scan_en_i(scan), .fbc_data_vld_i(dvld),
    .fbc_data_i(data), .fbc_cache_full_i(full), .fbc_scan_en_o(scan_o8),
    .fbc_cache_vld_o(vld8), .fbc_cache_data_o(data8), .frame_word_cnt_o(cnt8),
    .overflow_o(ovf8), .fsm_state_o(st8)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every presented word must match the oldest expected word.
  always @(negedge clk) begin
    if (vld1 === 1'b1) begin
      if (exp_q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL word_b1: got unexpected word %0h", data1);
      end else begin
        chk("word_b1", data1, exp_q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (vld8 === 1'b1) begin
      if (exp_q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL word_b8: got unexpected word %0h", data8);
      end else begin
        chk("word_b8", data8, exp_q8.pop_front());
      end
    end
  end

  function automatic logic [255:0] pack_word(input logic [31:0] s[$]);
    logic [255:0] w = {8{PAD}};
    for (int i = 0; i < s.size(); i++) w[i*32 +: 32] = s[i];
    return w;
  endfunction

  task automatic set_in(input bit s, input bit v, input bit f);
    scan = s; dvld = v; full = f; data = $urandom;
  endtask

  task automatic emit_or_drop(input bit f);
    if (f) begin
      ovf_exp = 1'b1;
    end else begin
      exp_q1.push_back(pack_word(part));
      exp_q8.push_back(pack_word(part));
      nw++;
    end
    part.delete();
  endtask

  task automatic take_sample(input bit f);
    part.push_back(data);
    if (part.size() == 8) emit_or_drop(f);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    set_in(0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    part.delete(); exp_q1.delete(); exp_q8.delete();
    chk("rst_vld1", 256'(vld1), 256'(0));
    chk("rst_vld8", 256'(vld8), 256'(0));
    chk("rst_scan1", 256'(scan_o1), 256'(0));
    chk("rst_scan8", 256'(scan_o8), 256'(0));
    chk("rst_cnt8", 256'(cnt8), 256'(0));
    chk("rst_ovf8", 256'(ovf8), 256'(0));
    chk("rst_data1", data1, 256'(0));
  endtask

  task automatic run_frame(input int n, input int full_pct);
    int  sent = 0;
    int  pads;
    bit  fall_with_sample;
    bit  v, f;
    bit  done_wait = 0;
    nw = 0; ovf_exp = 0; part.delete();
    fall_with_sample = (n > 0) && ($urandom_range(0, 1) == 1);
    set_in(1, 0, 0);
    @(negedge clk);
    while (sent < n) begin
      f = ($urandom_range(0, 99) < full_pct);
      if (fall_with_sample && sent == n - 1) begin
        set_in(0, 1, f);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        set_in(1, v, f);
      end
      if (dvld) begin
        take_sample(f);
        sent++;
      end
      @(negedge clk);
    end
    if (!fall_with_sample) begin
      set_in(0, 0, 0);
      @(negedge clk);
    end
    // Flush cycle: a late sample with scan low is simply ignored.
    f = ($urandom_range(0, 99) < full_pct * 4);
    set_in(0, $urandom_range(0, 1), f);
    if (part.size() != 0) emit_or_drop(f);
    pads = (8 - (nw % 8)) % 8;
    for (int i = 0; i < pads; i++) exp_q8.push_back({8{PAD}});
    @(negedge clk);
    // Both packers are padding now; this rise must not restart a frame.
    set_in(1, 0, $urandom_range(0, 1));
    @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      if (scan_o1 == 1'b0 && scan_o8 == 1'b0) begin
        done_wait = 1;
        break;
      end
      set_in(0, $urandom_range(0, 1), (full_pct > 0) && ($urandom_range(0, 2) == 0));
      @(negedge clk);
    end
    if (!done_wait) begin
      tests++; fails++;
      $display("FAIL frame_end_timeout: got scan_o1=%0b scan_o8=%0b required both 0", scan_o1, scan_o8);
      apply_reset();
      return;
    end
    for (int k = 0; k < 4; k++) begin
      set_in(0, $urandom_range(0, 1), $urandom_range(0, 1));
      @(negedge clk);
    end
    chk("cnt_b1", 256'(cnt1), 256'(nw));
    chk("cnt_b8", 256'(cnt8), 256'(nw + pads));
    chk("ovf_b1", 256'(ovf1), 256'(ovf_exp));
    chk("ovf_b8", 256'(ovf8), 256'(ovf_exp));
    chk("drain_b1", 256'(exp_q1.size()), 256'(0));
    chk("drain_b8", 256'(exp_q8.size()), 256'(0));
    chk("idle_scan8", 256'(scan_o8), 256'(0));
  endtask

  task automatic mid_frame_reset();
    set_in(1, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 0);
      @(negedge clk);
    end
    apply_reset();
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0);
    @(negedge clk);
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      set_in(0, 1, $urandom_range(0, 1));
      @(negedge clk);
    end
    chk("lowscan_ovf1", 256'(ovf1), 256'(0));
    chk("lowscan_cnt1", 256'(cnt1), 256'(0));
    run_frame(16, 0);
    run_frame(11, 0);
    run_frame(20, 0);
    run_frame(0, 0);
    run_frame(24, 20);
    mid_frame_reset();
    run_frame(13, 0);
    for (int r = 0; r < 25; r++) run_frame($urandom_range(0, 40), $urandom_range(0, 1) * 10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
